// File: rtl/multi_edge_detector_if.sv
// Signal bundle for multi_edge_detector: asynchronous inputs, per-channel mode/clear,
// filtered levels, edge pulses, sticky flags and the combined interrupt.
interface multi_edge_detector_if #(
  parameter int NCH = 4
);
  logic [NCH-1:0]   sig_in;
  logic [2*NCH-1:0] mode;
  logic [NCH-1:0]   flag_clr;
  logic [NCH-1:0]   level;
  logic [NCH-1:0]   rising_edge;
  logic [NCH-1:0]   falling_edge;
  logic [NCH-1:0]   event_flags;
  logic             irq;

  modport master (
    output sig_in, mode, flag_clr,
    input  level, rising_edge, falling_edge, event_flags, irq
  );

  modport slave (
    input  sig_in, mode, flag_clr,
    output level, rising_edge, falling_edge, event_flags, irq
  );
endinterface

// File: rtl/multi_edge_detector.sv
// Per-channel synchroniser, optional glitch filter (EDGE_DET_FILTER_EN), edge pulses,
// sticky event flags and an OR-reduced interrupt.
module multi_edge_detector #(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multi_edge_detector_if.slave  bus
);

  logic [NCH-1:0] flags_vec;

  if (NCH < 1 || NCH > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
      FILT_CYCLES < 1 || FILT_CYCLES > 255) begin : g_param_check
    $error("multi_edge_detector: parameter out of range");
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_reg;
      logic sync_bit;
      logic level_reg;
      logic level_next;
      logic rise_reg;
      logic fall_reg;
      logic flag_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_reg <= '0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.sig_in[gi]};
        end
      end

      assign sync_bit = sync_reg[SYNC_STAGES-1];

`ifdef EDGE_DET_FILTER_EN
      localparam int CW = $clog2(FILT_CYCLES + 1);
      logic [CW-1:0] cnt_reg;
      logic [CW-1:0] cnt_next;

      // Count consecutive disagreeing cycles; any agreement restarts the count.
      always_comb begin
        cnt_next   = '0;
        level_next = level_reg;
        if (sync_bit != level_reg) begin
          if (cnt_reg == CW'(FILT_CYCLES - 1)) begin
            level_next = ~level_reg;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end
`else
      assign level_next = sync_bit;
`endif

      // Pulses are registered alongside the level so they coincide with its change.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          level_reg <= 1'b0;
          rise_reg  <= 1'b0;
          fall_reg  <= 1'b0;
          flag_reg  <= 1'b0;
        end else begin
          level_reg <= level_next;
          rise_reg  <= level_next & ~level_reg & bus.mode[2*gi];
          fall_reg  <= ~level_next & level_reg & bus.mode[2*gi+1];
          flag_reg  <= (flag_reg & ~bus.flag_clr[gi]) | rise_reg | fall_reg;
        end
      end

      assign bus.level[gi]        = level_reg;
      assign bus.rising_edge[gi]  = rise_reg;
      assign bus.falling_edge[gi] = fall_reg;
      assign flags_vec[gi]        = flag_reg;
    end
  endgenerate

  assign bus.event_flags = flags_vec;
  assign bus.irq         = |flags_vec;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed, table-driven bench for multi_edge_detector (NCH=4, SYNC_STAGES=2, FILT_CYCLES=4).
module tb_multi_edge_detector;

  localparam int SYNC = 2;
  localparam int FILT = 4;
`ifdef EDGE_DET_FILTER_EN
  localparam int LAT = SYNC + FILT - 1;
`else
  localparam int LAT = SYNC;
`endif

  typedef struct {
    logic [3:0] sig;
    logic [7:0] mode;
    logic [3:0] clr;
    int         n;
    logic [3:0] lv;
    logic [3:0] ri;
    logic [3:0] fa;
    logic [3:0] fl;
    logic       irq;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[$];

  multi_edge_detector_if #(.NCH(4)) bus ();

  multi_edge_detector #(
    .NCH(4), .SYNC_STAGES(SYNC), .FILT_CYCLES(FILT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end else begin
      $display("ok   %s: %0h", name, got);
    end
  endtask

  task automatic add(input logic [3:0] s, input logic [7:0] m, input logic [3:0] c, input int n,
                     input logic [3:0] lv, input logic [3:0] ri, input logic [3:0] fa,
                     input logic [3:0] fl);
    vec_t v;
    v.sig = s; v.mode = m; v.clr = c; v.n = n;
    v.lv = lv; v.ri = ri; v.fa = fa; v.fl = fl; v.irq = (fl != 4'h0);
    vecs.push_back(v);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_level"}, 32'(bus.level), 32'h0);
    chk({tag, "_rise"},  32'(bus.rising_edge), 32'h0);
    chk({tag, "_fall"},  32'(bus.falling_edge), 32'h0);
    chk({tag, "_flags"}, 32'(bus.event_flags), 32'h0);
    chk({tag, "_irq"},   32'(bus.irq), 32'h0);
  endtask

  initial begin
    int rise_cnt;
    int fall_cnt;
    int rise_at;
    int fall_at;
    int lvl_hi;

    rst_n        = 1'b0;
    bus.sig_in   = 4'h0;
    bus.mode     = 8'hFF;
    bus.flag_clr = 4'h0;
    #3;
    chk_all_zero("reset");
    step();
    step();
    rst_n = 1'b1;

    // clean step, stickiness, lone clear, clear/set race on ch0
    add(4'h0, 8'hFF, 4'h0, 3,     4'h0, 4'h0, 4'h0, 4'h0);
    add(4'h1, 8'hFF, 4'h0, LAT,   4'h0, 4'h0, 4'h0, 4'h0);
    add(4'h1, 8'hFF, 4'h0, 1,     4'h1, 4'h1, 4'h0, 4'h0);
    add(4'h1, 8'hFF, 4'h0, 1,     4'h1, 4'h0, 4'h0, 4'h1);
    add(4'h1, 8'hFF, 4'h0, 2,     4'h1, 4'h0, 4'h0, 4'h1);
    add(4'h1, 8'hFF, 4'h1, 1,     4'h1, 4'h0, 4'h0, 4'h0);
    add(4'h0, 8'hFF, 4'h0, LAT+1, 4'h0, 4'h0, 4'h1, 4'h0);
    add(4'h0, 8'hFF, 4'h1, 1,     4'h0, 4'h0, 4'h0, 4'h1);
    add(4'h0, 8'hFF, 4'h0, 1,     4'h0, 4'h0, 4'h0, 4'h1);
    add(4'h0, 8'hFF, 4'h1, 1,     4'h0, 4'h0, 4'h0, 4'h0);
    // ch2 rising-only mode
    add(4'h4, 8'hDF, 4'h0, LAT+1, 4'h4, 4'h4, 4'h0, 4'h0);
    add(4'h4, 8'hDF, 4'h0, 1,     4'h4, 4'h0, 4'h0, 4'h4);
    add(4'h4, 8'hDF, 4'h4, 1,     4'h4, 4'h0, 4'h0, 4'h0);
    add(4'h0, 8'hDF, 4'h0, LAT+1, 4'h0, 4'h0, 4'h0, 4'h0);
    add(4'h0, 8'hDF, 4'h0, 1,     4'h0, 4'h0, 4'h0, 4'h0);
    // ch2 mode off: level tracks, nothing else
    add(4'h4, 8'hCF, 4'h0, LAT+1, 4'h4, 4'h0, 4'h0, 4'h0);
    add(4'h4, 8'hCF, 4'h0, 1,     4'h4, 4'h0, 4'h0, 4'h0);
    add(4'h0, 8'hCF, 4'h0, LAT+1, 4'h0, 4'h0, 4'h0, 4'h0);
    add(4'h0, 8'hCF, 4'h0, 1,     4'h0, 4'h0, 4'h0, 4'h0);
    // simultaneous edges on ch0, ch1, ch3
    add(4'hB, 8'hFF, 4'h0, LAT+1, 4'hB, 4'hB, 4'h0, 4'h0);
    add(4'hB, 8'hFF, 4'h0, 1,     4'hB, 4'h0, 4'h0, 4'hB);
    add(4'hB, 8'hFF, 4'hF, 1,     4'hB, 4'h0, 4'h0, 4'h0);
    add(4'h0, 8'hFF, 4'h0, LAT+1, 4'h0, 4'h0, 4'hB, 4'h0);
    add(4'h0, 8'hFF, 4'h0, 1,     4'h0, 4'h0, 4'h0, 4'hB);
    add(4'h0, 8'hFF, 4'hF, 1,     4'h0, 4'h0, 4'h0, 4'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      bus.sig_in   = vecs[i].sig;
      bus.mode     = vecs[i].mode;
      bus.flag_clr = vecs[i].clr;
      for (int k = 0; k < vecs[i].n; k++) step();
      chk($sformatf("v%0d_level", i), 32'(bus.level),        32'(vecs[i].lv));
      chk($sformatf("v%0d_rise", i),  32'(bus.rising_edge),  32'(vecs[i].ri));
      chk($sformatf("v%0d_fall", i),  32'(bus.falling_edge), 32'(vecs[i].fa));
      chk($sformatf("v%0d_flags", i), 32'(bus.event_flags),  32'(vecs[i].fl));
      chk($sformatf("v%0d_irq", i),   32'(bus.irq),          32'(vecs[i].irq));
    end
    bus.flag_clr = 4'h0;
    bus.mode     = 8'hFF;

    // 3-cycle glitch on ch1
    rise_cnt = 0; fall_cnt = 0; rise_at = -1; fall_at = -1; lvl_hi = 0;
    bus.sig_in = 4'h2;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 3) bus.sig_in = 4'h0;
      if (bus.rising_edge[1])  begin rise_cnt++; rise_at = k; end
      if (bus.falling_edge[1]) begin fall_cnt++; fall_at = k; end
      if (bus.level[1]) lvl_hi++;
    end
`ifdef EDGE_DET_FILTER_EN
    chk("glitch_rise_cnt", 32'(rise_cnt), 32'd0);
    chk("glitch_fall_cnt", 32'(fall_cnt), 32'd0);
    chk("glitch_level_hi", 32'(lvl_hi), 32'd0);
    chk("glitch_flags", 32'(bus.event_flags), 32'h0);
`else
    chk("glitch_rise_cnt", 32'(rise_cnt), 32'd1);
    chk("glitch_fall_cnt", 32'(fall_cnt), 32'd1);
    chk("glitch_rise_at", 32'(rise_at), 32'(LAT + 1));
    chk("glitch_fall_at", 32'(fall_at), 32'(LAT + 4));
    chk("glitch_flags", 32'(bus.event_flags), 32'h2);
`endif
    bus.flag_clr = 4'hF;
    step();
    bus.flag_clr = 4'h0;
    chk("glitch_cleared", 32'(bus.event_flags), 32'h0);

    // reset asserted mid-filter, input held high through release
    bus.sig_in = 4'h8;
    for (int k = 0; k < LAT; k++) step();
    chk("prereset_level", 32'(bus.level), 32'h0);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    step();
    step();
    chk_all_zero("held_reset");
    rst_n = 1'b1;
    rise_cnt = 0; rise_at = -1;
    for (int k = 1; k <= LAT + 4; k++) begin
      step();
      if (bus.rising_edge[3]) begin rise_cnt++; rise_at = k; end
    end
    chk("post_reset_rise_cnt", 32'(rise_cnt), 32'd1);
    chk("post_reset_rise_at", 32'(rise_at), 32'(LAT + 1));
    chk("post_reset_level", 32'(bus.level), 32'h8);
    chk("post_reset_flags", 32'(bus.event_flags), 32'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_edge_detector.md
MULTI_EDGE_DETECTOR -- requirements
Module: multi_edge_detector

Interface
REQ-001 SHALL have parameter NCH, default 4: number of independent channels, range 1..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth, range 2..4.
REQ-003 SHALL have parameter FILT_CYCLES, default 4: consecutive cycles of stable input required before the filtered level changes, range 1..255.
REQ-004 SHALL have port clk, input, 1: the single clock; every register is clocked on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port sig_in, input, NCH: asynchronous input signals, one bit per channel.
REQ-007 SHALL have port mode, input, 2*NCH: per-channel detect mode in bits [2i+1:2i]; 00 off, 01 rising, 10 falling, 11 both.
REQ-008 SHALL have port flag_clr, input, NCH: per-channel clear strobe for the sticky flags.
REQ-009 SHALL have port level, output, NCH: filtered, synchronised level.
REQ-010 SHALL have port rising_edge, output, NCH: one-cycle pulse on a qualified rising edge.
REQ-011 SHALL have port falling_edge, output, NCH: one-cycle pulse on a qualified falling edge.
REQ-012 SHALL have port event_flags, output, NCH: sticky record of qualified edges.
REQ-013 SHALL have port irq, output, 1: OR-reduction of event_flags.

Function
REQ-014 SHALL pass each sig_in bit through a chain of SYNC_STAGES flops; the output of the last flop is sync[i].
REQ-015 SHALL keep one counter per channel, ceil(log2(FILT_CYCLES+1)) bits wide; it increments each cycle in which sync[i] != level[i].
REQ-016 SHALL clear the counter in any cycle in which sync[i] == level[i], so a glitch shorter than FILT_CYCLES cycles is discarded.
REQ-017 SHALL toggle level[i] and clear the counter at the edge where the counter equals FILT_CYCLES-1 while sync[i] != level[i].
REQ-018 SHALL give the following latency: a step first captured by stage 1 at edge E changes level at edge E+SYNC_STAGES-1+FILT_CYCLES.
REQ-019 SHALL register rising_edge[i] high for exactly one cycle, at the same edge level[i] goes 0->1, only if mode bit 2i is 1.
REQ-020 SHALL register falling_edge[i] high for exactly one cycle, at the same edge level[i] goes 1->0, only if mode bit 2i+1 is 1.
REQ-021 SHALL set event_flags[i] one cycle after a rising_edge[i] or falling_edge[i] pulse; it stays set until cleared.
REQ-022 SHALL clear event_flags[i] at the clock edge where flag_clr[i] is 1; if a set and a clear coincide, the set wins.
REQ-023 SHALL drive irq combinationally from the event_flags registers only.
REQ-024 SHALL apply mode changes from the next edge onward, without disturbing the synchroniser, counter, level or flags.
REQ-025 SHALL never produce pulses while mode is 00, but SHALL continue to track level.
REQ-026 SHALL keep channels fully independent; simultaneous edges on any subset of channels SHALL all be reported in the same cycle.

Reset
REQ-027 SHALL clear all synchroniser flops, counters, level, rising_edge, falling_edge, event_flags and irq asynchronously when rst_n is 0.
REQ-028 SHALL release reset synchronously from the system's point of view; the first update occurs at the first clk edge with rst_n high.
REQ-029 SHALL report a rising edge (subject to mode) after the REQ-018 latency when an input is held high through reset release.
REQ-030 SHALL abort any in-flight filtering when reset is asserted mid-operation, and SHALL emit no pulse for it.

Configuration
REQ-031 SHALL compile the glitch filter of REQ-015..REQ-017 only when macro EDGE_DET_FILTER_EN is defined.
REQ-032 SHALL, when EDGE_DET_FILTER_EN is undefined, omit the counters, make level a register copy of sync (latency E+SYNC_STAGES), and ignore FILT_CYCLES.

Verification
REQ-033 SHALL cover a clean step: NCH=4, SYNC_STAGES=2, FILT_CYCLES=4, mode=2'b11 on ch0; sig_in[0] steps 0->1 at edge E -> level[0] and a one-cycle rising_edge[0] at E+5, event_flags[0]=1 and irq=1 at E+6.
REQ-034 SHALL cover glitch rejection: a 3-cycle high pulse on sig_in[1] with FILT_CYCLES=4 -> no level change, no pulse, flags stay 0; with the macro undefined -> rising_edge then falling_edge pulses 3 cycles apart.
REQ-035 SHALL cover mode gating: ch2 mode=01 with a full 0->1->0 cycle -> only rising_edge[2] pulses; mode=00 -> level[2] follows, no pulses, no flag.
REQ-036 SHALL cover the clear race: flag_clr[0]=1 in the same cycle a new edge sets the flag -> event_flags[0] stays 1; flag_clr[0]=1 alone -> 0 at the next edge, irq falls.
REQ-037 SHALL cover reset: rst_n pulled low mid-filter with sig_in[3]=1 -> all outputs 0 immediately; after release with sig_in[3] held high -> one rising_edge[3] after 5 cycles.
